button_event_arbiter: RTL and testbench
=======================================

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 SHALL have parameter N_BUTTONS, default 4, number of button channels (range 2..16).
REQ-002 SHALL have parameter SYNC_BITS, default 3, synchroniser depth per channel (minimum 2).
REQ-003 SHALL have parameter STABLE_COUNT, default 270000, consecutive cycles a new level must persist before it is accepted.
REQ-004 SHALL have parameter LONG_COUNT, default 27000000, hold cycles that define a long press (used only with LONG_PRESS_EN).
REQ-005 SHALL have port clock  input  1  the only clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port btn_in  input  N_BUTTONS  raw asynchronous active-high buttons.
REQ-008 SHALL have port btn_state  output  N_BUTTONS  debounced level per channel.
REQ-009 SHALL have port evt_valid  output  1  event offered.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts the event.
REQ-011 SHALL have port evt_id  output  IDW  channel index of the offered event; IDW = max(1, clog2(N_BUTTONS)).
REQ-012 SHALL have port evt_long  output  1  offered event is a long press.
REQ-013 SHALL have port overflow  output  1  one-cycle pulse when a press is lost.

Function
REQ-014 Each btn_in bit SHALL pass through its own SYNC_BITS-stage shift-register synchroniser; debounce logic SHALL use only the last stage.
REQ-015 Per channel, while the synchronised level equals btn_state, the debounce counter SHALL be held at 0.
REQ-016 While the synchronised level differs from btn_state, the counter SHALL increment each cycle; on the cycle it equals STABLE_COUNT-1, btn_state SHALL toggle and the counter SHALL clear.
REQ-017 Any single-cycle return to agreement SHALL clear the counter, so glitches shorter than STABLE_COUNT cycles never change btn_state.
REQ-018 A 0->1 transition of btn_state at edge E SHALL set pending[i] at edge E+1; 1->0 transitions SHALL generate no event.
REQ-019 If pending[i] is already set and not being granted when a new press arrives, overflow SHALL pulse for one cycle and pending[i] SHALL remain set (events merge).
REQ-020 If a new press sets pending[i] in the same cycle that pending[i] is cleared by a grant, set SHALL win and overflow SHALL stay 0.
REQ-021 Arbiter states: IDLE and OFFER.
REQ-022 In IDLE with any request, the arbiter SHALL select the first requesting channel in round-robin order, starting at last_grant+1 and wrapping from N_BUTTONS-1 to 0.
REQ-023 On that edge the arbiter SHALL load evt_id, clear the granted pending bit, set evt_valid=1, update last_grant, and enter OFFER.
REQ-024 In OFFER, evt_id and evt_long SHALL be held stable until evt_ready is sampled 1; on that edge evt_valid SHALL go 0 and the state SHALL return to IDLE.
REQ-025 Latency from btn_state rising at E to evt_valid with an idle arbiter SHALL be 2 cycles (E+2); maximum throughput is one event per 2 cycles.
REQ-026 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-027 While rst_n=0, all synchronisers, counters, btn_state, pending bits, evt_valid, evt_id, evt_long and overflow SHALL be 0, the state SHALL be IDLE, and last_grant SHALL be N_BUTTONS-1, so channel 0 has first priority.
REQ-028 Reset asserted mid-OFFER SHALL drop evt_valid asynchronously and discard all pending events; no event SHALL be emitted after release until a fresh debounced press occurs.

Configuration
REQ-029 With macro BUTTON_EVENT_LONG_PRESS_EN defined, each channel SHALL count cycles while btn_state=1, and on reaching LONG_COUNT SHALL set pending_long[i] once per hold, with the counter saturating until release.
REQ-030 With the macro defined, a channel SHALL request when pending|pending_long is set; if both are set, the short event SHALL be granted first with evt_long=0, then the long event with evt_long=1; a lost long press SHALL pulse overflow.
REQ-031 Without the macro, no hold counters or pending_long state SHALL exist and evt_long SHALL be constant 0.

Verification (N_BUTTONS=4, SYNC_BITS=3, STABLE_COUNT=8, LONG_COUNT=40)
REQ-032 Glitch test: btn_in[1] high for 7 cycles then low -> btn_state stays 0000 and no evt_valid.
REQ-033 Clean press: btn_in[2] held high -> btn_state[2]=1 on cycle 3+8 after the input edge; evt_valid follows 2 cycles later with evt_id=2 and evt_long=0.
REQ-034 Round-robin: channels 0, 1 and 3 pressed simultaneously with evt_ready=1 -> evt_id sequence 0, 1, 3 with evt_valid spacing of 2 cycles; next simultaneous 0+1 -> order 0, 1.
REQ-035 Back-pressure and overflow: evt_ready=0, channel 0 pressed twice while pending -> one overflow pulse, exactly one id=0 event once evt_ready=1, and evt_id stable throughout OFFER.
REQ-036 Reset mid-OFFER: rst_n low for 1 cycle during evt_valid=1 -> evt_valid=0 immediately, no event after release.
REQ-037 With BUTTON_EVENT_LONG_PRESS_EN: channel 3 held 60 cycles -> id=3/long=0, then id=3/long=1, exactly once each.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Purpose: per-channel button synchroniser + debouncer feeding a round-robin press-event arbiter.
// Latency: debounced press (btn_state rise at edge E) -> evt_valid at E+2 when idle; max one event per 2 cycles.
// Backpressure: offered event held until evt_ready; a repeat press of a still-pending channel merges and pulses overflow.
// Ports: clock, rst_n (async active-low); btn_in raw buttons; btn_state debounced levels;
//        evt_valid/evt_ready/evt_id/evt_long event handshake; overflow one-cycle lost-press pulse.
// Option: define BUTTON_EVENT_LONG_PRESS_EN to add long-press events (evt_long=1) after LONG_COUNT hold cycles.
module button_event_arbiter #(
   parameter int N_BUTTONS    = 4,
   parameter int SYNC_BITS    = 3,
   parameter int STABLE_COUNT = 270000,
   parameter int LONG_COUNT   = 27000000,
   localparam int IDW = (N_BUTTONS > 2) ? $clog2(N_BUTTONS) : 1
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic [N_BUTTONS-1:0] btn_in,
   output logic [N_BUTTONS-1:0] btn_state,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [IDW-1:0]       evt_id,
   output logic                 evt_long,
   output logic                 overflow
);

   localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;

   if (N_BUTTONS < 2 || N_BUTTONS > 16 || SYNC_BITS < 2 || STABLE_COUNT < 1 || LONG_COUNT < 1)
   begin : g_param_check
      $error("button_event_arbiter: parameter out of range");
   end

   typedef enum logic {ST_IDLE, ST_OFFER} arb_state_t;

   logic [SYNC_BITS-1:0] sync_q [N_BUTTONS];
   logic [CW-1:0]        db_cnt [N_BUTTONS];
   logic [N_BUTTONS-1:0] btn_prev;
   logic [N_BUTTONS-1:0] rise;
   logic [N_BUTTONS-1:0] pending;
   logic [N_BUTTONS-1:0] req;
   logic [N_BUTTONS-1:0] sel_onehot;
   logic [N_BUTTONS-1:0] grant_short;
   logic [N_BUTTONS-1:0] grant_long;
   logic [N_BUTTONS-1:0] long_hit;
   logic [IDW-1:0]       last_grant;
   logic [IDW-1:0]       sel;
   logic [IDW-1:0]       cand;
   logic                 sel_found;
   logic                 grant_now;
   arb_state_t           arb_state;
   int                   rr_idx;

   // Synchroniser and debounce: only the last sync stage is looked at.
   // The counter measures how long the synced level has disagreed with btn_state.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BUTTONS; i++) begin
            sync_q[i] <= '0;
            db_cnt[i] <= '0;
         end
         btn_state <= '0;
         btn_prev  <= '0;
      end else begin
         btn_prev <= btn_state;
         for (int i = 0; i < N_BUTTONS; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_BITS-2:0], btn_in[i]};
            if (sync_q[i][SYNC_BITS-1] == btn_state[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CW'(STABLE_COUNT - 1)) begin
               db_cnt[i]    <= '0;
               btn_state[i] <= ~btn_state[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign rise = btn_state & ~btn_prev;

`ifdef BUTTON_EVENT_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_COUNT + 1);

   logic [LW-1:0]        hold_cnt [N_BUTTONS];
   logic [N_BUTTONS-1:0] pending_long;
   logic                 evt_long_q;

   // The hold counter saturates at LONG_COUNT, so the hit fires once per hold.
   always_comb begin
      long_hit = '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
         long_hit[i] = btn_state[i] && (hold_cnt[i] == LW'(LONG_COUNT - 1));
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BUTTONS; i++) begin
            hold_cnt[i] <= '0;
         end
         pending_long <= '0;
      end else begin
         for (int i = 0; i < N_BUTTONS; i++) begin
            if (!btn_state[i]) begin
               hold_cnt[i] <= '0;
            end else if (hold_cnt[i] != LW'(LONG_COUNT)) begin
               hold_cnt[i] <= hold_cnt[i] + LW'(1);
            end
         end
         pending_long <= (pending_long & ~grant_long) | long_hit;
      end
   end

   assign req      = pending | pending_long;
   assign evt_long = evt_long_q;
`else
   assign long_hit = '0;
   assign req      = pending;
   assign evt_long = 1'b0;
`endif

   // Round-robin pick: first requester at or after last_grant+1, wrapping.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      rr_idx    = 0;
      cand      = '0;
      for (int k = 1; k <= N_BUTTONS; k++) begin
         rr_idx = (int'(last_grant) + k) % N_BUTTONS;
         cand   = IDW'(rr_idx);
         if (!sel_found && req[cand]) begin
            sel       = cand;
            sel_found = 1'b1;
         end
      end
   end

   assign grant_now   = (arb_state == ST_IDLE) && sel_found;
   assign sel_onehot  = N_BUTTONS'(1) << sel;
   // A short event on the chosen channel always goes before its long event.
   assign grant_short = (grant_now &&  pending[sel]) ? sel_onehot : '0;
   assign grant_long  = (grant_now && !pending[sel]) ? sel_onehot : '0;

   // A new press on the same edge as its grant re-arms pending (set wins, no overflow).
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         pending  <= (pending & ~grant_short) | rise;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
         overflow <= (|(rise & pending & ~grant_short)) ||
                     (|(long_hit & pending_long & ~grant_long));
`else
         overflow <= |(rise & pending & ~grant_short);
`endif
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         arb_state  <= ST_IDLE;
         evt_valid  <= 1'b0;
         evt_id     <= '0;
         last_grant <= IDW'(N_BUTTONS - 1);
`ifdef BUTTON_EVENT_LONG_PRESS_EN
         evt_long_q <= 1'b0;
`endif
      end else if (arb_state == ST_IDLE) begin
         if (sel_found) begin
            evt_id     <= sel;
            evt_valid  <= 1'b1;
            last_grant <= sel;
            arb_state  <= ST_OFFER;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
            evt_long_q <= !pending[sel];
`endif
         end
      end else if (evt_ready) begin
         evt_valid <= 1'b0;
         arb_state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Purpose: randomized + directed bench for button_event_arbiter against a behavioural model.
// Latency: model predicts every output each cycle; outputs sampled on the falling edge.
// Backpressure: evt_ready driven directly (held low, held high, and random).
module tb_button_event_arbiter;
   localparam int N            = 4;
   localparam int SYNC_BITS    = 3;
   localparam int STABLE_COUNT = 8;
   localparam int LONG_COUNT   = 40;
`ifdef BUTTON_EVENT_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic         clock     = 1'b0;
   logic         rst_n     = 1'b0;
   logic         evt_ready = 1'b0;
   logic [N-1:0] btn_in    = '0;
   logic [N-1:0] btn_state;
   logic         evt_valid;
   logic [1:0]   evt_id;
   logic         evt_long;
   logic         overflow;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   int ovf_cnt = 0;
   int q_id [$];
   int q_long [$];
   int q_cyc [$];

   button_event_arbiter #(
      .N_BUTTONS(N), .SYNC_BITS(SYNC_BITS), .STABLE_COUNT(STABLE_COUNT), .LONG_COUNT(LONG_COUNT)
   ) dut (
      .clock(clock), .rst_n(rst_n), .btn_in(btn_in), .btn_state(btn_state),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_long(evt_long), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Input history is a circular buffer of raw samples; the debouncer is a
   // run length of consecutive disagreeing cycles; pending is a set of channels.
   logic [2:0]   m_ptr;
   logic [N-1:0] m_samp [8];
   int           m_run [N];
   int           m_hold [N];
   logic [N-1:0] m_state, m_rise, m_pend, m_plong;
   logic         m_valid, m_long, m_ovf;
   int           m_id, m_last;

   logic [N-1:0] lvl, n_state, n_rise, n_pend, n_plong, long_hit, req, g_short, g_long;
   int           n_run [N];
   int           n_hold [N];
   logic         n_valid, n_long, n_ovf, found;
   int           n_id, n_last, c;

   always_comb begin
      lvl      = m_samp[m_ptr - 3'(SYNC_BITS)];
      n_state  = m_state;
      n_rise   = '0;
      long_hit = '0;
      for (int i = 0; i < N; i++) begin
         n_run[i]  = 0;
         n_hold[i] = 0;
         if (lvl[i] != m_state[i]) begin
            if (m_run[i] + 1 == STABLE_COUNT) begin
               n_state[i] = ~m_state[i];
               n_rise[i]  = ~m_state[i];
            end else begin
               n_run[i] = m_run[i] + 1;
            end
         end
         if (m_state[i]) begin
            n_hold[i]   = (m_hold[i] < LONG_COUNT) ? m_hold[i] + 1 : LONG_COUNT;
            long_hit[i] = LONG_EN && (m_hold[i] + 1 == LONG_COUNT);
         end
      end
      req     = m_pend | m_plong;
      n_valid = m_valid;
      n_id    = m_id;
      n_last  = m_last;
      n_long  = m_long;
      g_short = '0;
      g_long  = '0;
      found   = 1'b0;
      c       = 0;
      if (!m_valid) begin
         for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (!found && req[c]) begin
               found   = 1'b1;
               n_valid = 1'b1;
               n_id    = c;
               n_last  = c;
               if (m_pend[c]) begin
                  g_short[c] = 1'b1;
                  n_long     = 1'b0;
               end else begin
                  g_long[c] = 1'b1;
                  n_long    = 1'b1;
               end
            end
         end
      end else if (evt_ready) begin
         n_valid = 1'b0;
      end
      n_ovf   = (|(m_rise & m_pend & ~g_short)) || (|(long_hit & m_plong & ~g_long));
      n_pend  = (m_pend & ~g_short) | m_rise;
      n_plong = (m_plong & ~g_long) | long_hit;
   end

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_ptr <= '0;
         for (int i = 0; i < 8; i++) m_samp[i] <= '0;
         for (int i = 0; i < N; i++) begin
            m_run[i]  <= 0;
            m_hold[i] <= 0;
         end
         m_state <= '0; m_rise <= '0; m_pend <= '0; m_plong <= '0;
         m_valid <= 1'b0; m_long <= 1'b0; m_ovf <= 1'b0;
         m_id    <= 0;    m_last <= N - 1;
      end else begin
         m_samp[m_ptr] <= btn_in;
         m_ptr         <= m_ptr + 3'd1;
         for (int i = 0; i < N; i++) begin
            m_run[i]  <= n_run[i];
            m_hold[i] <= n_hold[i];
         end
         m_state <= n_state; m_rise <= n_rise; m_pend <= n_pend; m_plong <= n_plong;
         m_valid <= n_valid; m_long <= n_long; m_ovf <= n_ovf;
         m_id    <= n_id;    m_last <= n_last;
      end
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Per-cycle comparison and event log, away from the rising edge.
   always @(negedge clock) begin
      chk("btn_state", btn_state, m_state);
      chk("evt_valid", evt_valid, m_valid);
      chk("evt_id",    evt_id,    m_id);
      chk("evt_long",  evt_long,  m_long);
      chk("overflow",  overflow,  m_ovf);
      if (rst_n && evt_valid && evt_ready) begin
         q_id.push_back(int'(evt_id));
         q_long.push_back(int'(evt_long));
         q_cyc.push_back(cyc);
      end
      if (overflow) ovf_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [N-1:0] m, input int hi, input int lo);
      btn_in = btn_in | m;
      tick(hi);
      btn_in = btn_in & ~m;
      tick(lo);
   endtask

   task automatic clear_log();
      q_id.delete();
      q_long.delete();
      q_cyc.delete();
      ovf_cnt = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m, c0, c1;
      #1;
      chk("rst_valid", evt_valid, 0);
      chk("rst_state", btn_state, 0);
      chk("rst_ovf",   overflow,  0);
      chk("rst_id",    evt_id,    0);
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Glitch shorter than the debounce window.
      evt_ready = 1'b1;
      clear_log();
      press(4'b0010, 7, 25);
      chk("glitch_state", btn_state, 0);
      chk("glitch_valid", evt_valid, 0);
      chk("glitch_evts",  q_id.size(), 0);

      // Round-robin from reset priority.
      clear_log();
      press(4'b1011, 15, 30);
      chk("rr1_count", q_id.size(), 3);
      if (q_id.size() == 3) begin
         chk("rr1_id0", q_id[0], 0);
         chk("rr1_id1", q_id[1], 1);
         chk("rr1_id2", q_id[2], 3);
         chk("rr1_gap0", q_cyc[1] - q_cyc[0], 2);
         chk("rr1_gap1", q_cyc[2] - q_cyc[1], 2);
      end
      clear_log();
      press(4'b0011, 15, 30);
      chk("rr2_count", q_id.size(), 2);
      if (q_id.size() == 2) begin
         chk("rr2_id0", q_id[0], 0);
         chk("rr2_id1", q_id[1], 1);
      end

      // Clean press latency.
      clear_log();
      btn_in[2] = 1'b1;
      n = 0;
      while (!btn_state[2] && n < 50) begin
         @(posedge clock); #1; n++;
      end
      chk("press_lat", n, SYNC_BITS + STABLE_COUNT);
      m = 0;
      while (!evt_valid && m < 10) begin
         @(posedge clock); #1; m++;
      end
      chk("valid_lat", m, 2);
      chk("press_id",   evt_id,   2);
      chk("press_long", evt_long, 0);
      tick(14);
      btn_in[2] = 1'b0;
      tick(30);

      // Back-pressure: ch1 occupies the offer, ch0 pressed twice meanwhile.
      evt_ready = 1'b0;
      clear_log();
      press(4'b0010, 15, 15);
      chk("bp_offer_id", evt_id, 1);
      press(4'b0001, 15, 15);
      press(4'b0001, 15, 15);
      chk("bp_held_valid", evt_valid, 1);
      chk("bp_held_id",    evt_id,    1);
      chk("bp_ovf_count",  ovf_cnt,   1);
      evt_ready = 1'b1;
      tick(20);
      chk("bp_count", q_id.size(), 2);
      if (q_id.size() == 2) begin
         chk("bp_first", q_id[0], 1);
         chk("bp_second", q_id[1], 0);
      end

      // Reset during an offer with another channel still pending.
      evt_ready = 1'b0;
      press(4'b1100, 15, 0);
      chk("pre_rst_valid", evt_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", evt_valid, 0);
      tick(1);
      rst_n = 1'b1;
      clear_log();
      evt_ready = 1'b1;
      tick(40);
      chk("rst_no_evt", q_id.size(), 0);

      // Randomized traffic: bounces of every length, random back-pressure.
      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 11) == 0) btn_in[i] = ~btn_in[i];
         end
         evt_ready = ($urandom_range(0, 3) != 0);
         tick(1);
      end
      btn_in    = '0;
      evt_ready = 1'b1;
      tick(60);

`ifdef BUTTON_EVENT_LONG_PRESS_EN
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      clear_log();
      press(4'b1000, 60, 30);
      c0 = 0;
      c1 = 0;
      foreach (q_id[i]) begin
         if (q_id[i] == 3 && q_long[i] == 0) c0++;
         if (q_id[i] == 3 && q_long[i] == 1) c1++;
      end
      chk("long_short_cnt", c0, 1);
      chk("long_long_cnt",  c1, 1);
      chk("long_total",     q_id.size(), 2);
      if (q_id.size() == 2) chk("long_order", q_long[0], 0);
`else
      c0 = 0;
      c1 = 0;
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
